// File: rtl/jtag_tap_oversampled.sv
// IEEE 1149.1 TAP with IR, IDCODE, BYPASS and one user DR, pins oversampled in the system clock domain.
// Optional macro JTAG_TAP_TCK_COUNT_EN adds a free-running tck_rise_count output.
module jtag_tap_oversampled #(
  parameter int unsigned         IR_WIDTH      = 5,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h00000001,
  parameter int unsigned         USER_DR_WIDTH = 32,
  parameter logic [IR_WIDTH-1:0] USER_IR       = 5'h10,
  parameter int unsigned         SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     jtag_TCK,
  input  logic                     jtag_TMS,
  input  logic                     jtag_TDI,
  input  logic                     jtag_TRSTn,
  output logic                     jtag_TDO_data,
  output logic                     jtag_TDO_driven,
  output logic [3:0]               tap_state,
  output logic [IR_WIDTH-1:0]      ir_value,
  input  logic [USER_DR_WIDTH-1:0] dr_capture_data,
  output logic                     dr_update_valid,
  output logic [USER_DR_WIDTH-1:0] dr_update_data
`ifdef JTAG_TAP_TCK_COUNT_EN
  ,
  output logic [31:0]              tck_rise_count
`endif
);

  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE,
    SH_IR = 4'hA, EX1_IR = 4'h9, PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(1'b1);
  // Pin order {TRSTn, TDI, TMS, TCK}; idle pin levels so reset never fakes an edge or a test reset.
  localparam logic [3:0] SYNC_RST = 4'b1010;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic tck_s, tms_s, tdi_s, trstn_s;
  logic tck_prev_q, rise_s, fall_s;
  tap_state_e state_q, state_d;
  logic [IR_WIDTH-1:0]      ir_shift_q, ir_value_q;
  logic [31:0]              idcode_shift_q;
  logic [USER_DR_WIDTH-1:0] user_shift_q, dr_update_data_q;
  logic bypass_q, tdo_data_q, tdo_driven_q, dr_update_valid_q;
  logic sel_idcode_s, sel_user_s, dr_lsb_s;

  assign {trstn_s, tdi_s, tms_s, tck_s} = sync_q[SYNC_STAGES-1];
  assign rise_s       = tck_s & ~tck_prev_q;
  assign fall_s       = ~tck_s & tck_prev_q;
  assign sel_idcode_s = (ir_value_q == IDCODE_OP);
  assign sel_user_s   = ~sel_idcode_s & (ir_value_q == USER_IR);

  // LSB of whichever data register the current instruction selects
  always_comb begin
    dr_lsb_s = bypass_q;
    if (sel_idcode_s) begin
      dr_lsb_s = idcode_shift_q[0];
    end else if (sel_user_s) begin
      dr_lsb_s = user_shift_q[0];
    end else begin
      dr_lsb_s = bypass_q;
    end
  end

  // IEEE 1149.1 next-state function on synchronized TMS
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = tms_s ? TLR    : RTI;
      RTI:      state_d = tms_s ? SEL_DR : RTI;
      SEL_DR:   state_d = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:   state_d = tms_s ? EX1_DR : SH_DR;
      SH_DR:    state_d = tms_s ? EX1_DR : SH_DR;
      EX1_DR:   state_d = tms_s ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_d = tms_s ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_d = tms_s ? UPD_DR : SH_DR;
      UPD_DR:   state_d = tms_s ? SEL_DR : RTI;
      SEL_IR:   state_d = tms_s ? TLR    : CAP_IR;
      CAP_IR:   state_d = tms_s ? EX1_IR : SH_IR;
      SH_IR:    state_d = tms_s ? EX1_IR : SH_IR;
      EX1_IR:   state_d = tms_s ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_d = tms_s ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_d = tms_s ? UPD_IR : SH_IR;
      UPD_IR:   state_d = tms_s ? SEL_DR : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Synchronizers, TAP state, instruction/data registers and TDO
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      tck_prev_q        <= 1'b0;
      state_q           <= TLR;
      ir_shift_q        <= '0;
      ir_value_q        <= IDCODE_OP;
      idcode_shift_q    <= 32'h0;
      user_shift_q      <= '0;
      bypass_q          <= 1'b0;
      tdo_data_q        <= 1'b0;
      tdo_driven_q      <= 1'b0;
      dr_update_valid_q <= 1'b0;
      dr_update_data_q  <= '0;
    end else begin
      sync_q[0] <= {jtag_TRSTn, jtag_TDI, jtag_TMS, jtag_TCK};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      tck_prev_q        <= tck_s;
      dr_update_valid_q <= 1'b0;
      if (!trstn_s) begin
        state_q    <= TLR;
        ir_value_q <= IDCODE_OP;
      end else if (rise_s) begin
        state_q <= state_d;
        // Capture/shift act on the rise that leaves the Capture/Shift state
        case (state_q)
          CAP_IR: ir_shift_q <= IR_WIDTH'(2'b01);
          SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
          CAP_DR: begin
            if (sel_idcode_s)    idcode_shift_q <= IDCODE_VALUE;
            else if (sel_user_s) user_shift_q   <= dr_capture_data;
            else                 bypass_q       <= 1'b0;
          end
          SH_DR: begin
            if (sel_idcode_s)    idcode_shift_q <= {tdi_s, idcode_shift_q[31:1]};
            else if (sel_user_s) user_shift_q   <= {tdi_s, user_shift_q[USER_DR_WIDTH-1:1]};
            else                 bypass_q       <= tdi_s;
          end
          default: ;
        endcase
        if (state_d == TLR)         ir_value_q <= IDCODE_OP;
        else if (state_d == UPD_IR) ir_value_q <= ir_shift_q;
        else                        ir_value_q <= ir_value_q;
        if ((state_d == UPD_DR) && sel_user_s) begin
          dr_update_data_q  <= user_shift_q;
          dr_update_valid_q <= 1'b1;
        end
      end
      if (fall_s) begin
        tdo_driven_q <= (state_q == SH_IR) || (state_q == SH_DR);
        tdo_data_q   <= (state_q == SH_IR) ? ir_shift_q[0] : dr_lsb_s;
      end
    end
  end

`ifdef JTAG_TAP_TCK_COUNT_EN
  logic [31:0] rise_cnt_q;

  // Counts every rise; deliberately untouched by TRSTn
  always_ff @(posedge clock) begin
    if (!reset) rise_cnt_q <= 32'h0;
    else if (rise_s) rise_cnt_q <= rise_cnt_q + 32'h1;
    else rise_cnt_q <= rise_cnt_q;
  end

  assign tck_rise_count = rise_cnt_q;
`endif

  assign tap_state       = state_q;
  assign ir_value        = ir_value_q;
  assign jtag_TDO_data   = tdo_data_q;
  assign jtag_TDO_driven = tdo_driven_q;
  assign dr_update_valid = dr_update_valid_q;
  assign dr_update_data  = dr_update_data_q;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Self-checking bench for jtag_tap_oversampled: state-walk table plus IDCODE, BYPASS, user DR, TRSTn and reset sequences.
module tb_jtag_tap_oversampled;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic        jtag_TDO_data, jtag_TDO_driven, dr_update_valid;
  logic [3:0]  tap_state;
  logic [4:0]  ir_value;
  logic [31:0] dr_capture_data, dr_update_data;
`ifdef JTAG_TAP_TCK_COUNT_EN
  logic [31:0] tck_rise_count;
`endif

  jtag_tap_oversampled dut (
    .clock(clock), .reset(reset), .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS),
    .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn), .jtag_TDO_data(jtag_TDO_data),
    .jtag_TDO_driven(jtag_TDO_driven), .tap_state(tap_state), .ir_value(ir_value),
    .dr_capture_data(dr_capture_data), .dr_update_valid(dr_update_valid),
    .dr_update_data(dr_update_data)
`ifdef JTAG_TAP_TCK_COUNT_EN
    , .tck_rise_count(tck_rise_count)
`endif
  );

  typedef struct packed {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic [4:0] ir;
  } vec_t;

  vec_t        tbl[27];
  logic [8:0]  sb_q[$];
  logic [1:0]  tdo_q[$];
  int          total = 0;
  int          bad = 0;
  int          pulse_cnt = 0;
  int          rises = 0;
  logic [31:0] pulse_data = 32'h0;

  // One count per clock that dr_update_valid is high
  always @(negedge clock) begin
    if (dr_update_valid === 1'b1) begin
      pulse_cnt++;
      pulse_data = dr_update_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One TCK period (8 clocks); TDO is sampled before the rise that shifts it out
  task automatic step(input logic t, input logic d, input logic chk, input logic e_drv, input logic e_tdo);
    logic [1:0] e;
    jtag_TMS = t;
    jtag_TDI = d;
    jtag_TCK = 1'b0;
    if (chk) tdo_q.push_back({e_drv, e_tdo});
    repeat (4) @(posedge clock);
    #1;
    if (chk) begin
      e = tdo_q.pop_front();
      check("tdo_driven", {31'h0, jtag_TDO_driven}, {31'h0, e[1]});
      if (e[1]) check("tdo_data", {31'h0, jtag_TDO_data}, {31'h0, e[0]});
    end
    jtag_TCK = 1'b1;
    rises++;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic shift_dr(input logic [31:0] tdi_v, input logic [31:0] exp_v, input int n);
    for (int i = 0; i < n; i++) step(i == n - 1, tdi_v[i], 1'b1, 1'b1, exp_v[i]);
  endtask

  // From RTI into Shift-DR, checking TDO is undriven while in Capture-DR
  task automatic goto_shdr();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("enter_shdr", {28'h0, tap_state}, 32'h2);
  endtask

  // From RTI: load an instruction and return to RTI; captured IR pattern is 01
  task automatic shift_ir(input logic [4:0] v);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(i == 4, v[i], 1'b1, 1'b1, i == 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("updir_state", {28'h0, tap_state}, 32'hD);
    check("ir_loaded", {27'h0, ir_value}, {27'h0, v});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [8:0] e;
    tbl = '{
      '{1'b1, 1'b0, 4'hF, 5'h01}, '{1'b1, 1'b0, 4'hF, 5'h01}, '{1'b1, 1'b0, 4'hF, 5'h01},
      '{1'b1, 1'b0, 4'hF, 5'h01}, '{1'b1, 1'b0, 4'hF, 5'h01},
      '{1'b0, 1'b0, 4'hC, 5'h01}, '{1'b1, 1'b0, 4'h7, 5'h01}, '{1'b0, 1'b0, 4'h6, 5'h01},
      '{1'b1, 1'b0, 4'h1, 5'h01}, '{1'b0, 1'b0, 4'h3, 5'h01}, '{1'b1, 1'b0, 4'h0, 5'h01},
      '{1'b0, 1'b0, 4'h2, 5'h01}, '{1'b1, 1'b0, 4'h1, 5'h01}, '{1'b1, 1'b0, 4'h5, 5'h01},
      '{1'b1, 1'b0, 4'h7, 5'h01}, '{1'b1, 1'b0, 4'h4, 5'h01}, '{1'b0, 1'b0, 4'hE, 5'h01},
      '{1'b1, 1'b0, 4'h9, 5'h01}, '{1'b0, 1'b0, 4'hB, 5'h01}, '{1'b1, 1'b0, 4'h8, 5'h01},
      '{1'b0, 1'b0, 4'hA, 5'h01}, '{1'b1, 1'b0, 4'h9, 5'h01}, '{1'b1, 1'b0, 4'hD, 5'h00},
      '{1'b0, 1'b0, 4'hC, 5'h00}, '{1'b1, 1'b0, 4'h7, 5'h00}, '{1'b1, 1'b0, 4'h4, 5'h00},
      '{1'b1, 1'b0, 4'hF, 5'h01}
    };
    reset = 1'b0; jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
    dr_capture_data = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_state", {28'h0, tap_state}, 32'hF);
    check("rst_ir", {27'h0, ir_value}, 32'h1);
    check("rst_drv", {31'h0, jtag_TDO_driven}, 32'h0);
    check("rst_tdo", {31'h0, jtag_TDO_data}, 32'h0);
    check("rst_valid", {31'h0, dr_update_valid}, 32'h0);
    reset = 1'b1;
    rises = 0;
    repeat (2) @(posedge clock);
    #1;

    // Full 16-state walk
    for (int i = 0; i < 27; i++) begin
      sb_q.push_back({tbl[i].st, tbl[i].ir});
      step(tbl[i].tms, tbl[i].tdi, 1'b0, 1'b0, 1'b0);
      e = sb_q.pop_front();
      check("walk_state", {28'h0, tap_state}, {28'h0, e[8:5]});
      check("walk_ir", {27'h0, ir_value}, {27'h0, e[4:0]});
    end

    // IDCODE readout
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    goto_shdr();
    shift_dr(32'h0, 32'h00000001, 32);
    check("ex1dr_state", {28'h0, tap_state}, 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("upddr_state", {28'h0, tap_state}, 32'h5);
    check("idcode_no_pulse", pulse_cnt, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // BYPASS: one-cycle delay with leading 0
    shift_ir(5'h1F);
    goto_shdr();
    shift_dr(32'h0000000D, 32'h0000000A, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bypass_no_pulse", pulse_cnt, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // User DR capture, shift and update handshake
    dr_capture_data = 32'hCAFEF00D;
    shift_ir(5'h10);
    goto_shdr();
    shift_dr(32'h12345678, 32'hCAFEF00D, 32);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("user_state", {28'h0, tap_state}, 32'h5);
    check("user_pulse_cnt", pulse_cnt, 32'h1);
    check("user_pulse_data", pulse_data, 32'h12345678);
    check("user_upd_data", dr_update_data, 32'h12345678);
    check("user_valid_low", {31'h0, dr_update_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // TRSTn dropped mid Shift-DR
    goto_shdr();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("pre_trst_state", {28'h0, tap_state}, 32'h2);
    jtag_TRSTn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("trst_state", {28'h0, tap_state}, 32'hF);
    check("trst_ir", {27'h0, ir_value}, 32'h1);
    jtag_TRSTn = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("trst_hold_state", {28'h0, tap_state}, 32'hF);
    check("trst_no_pulse", pulse_cnt, 32'h1);

    // Reset asserted mid Shift-IR
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("shir_state", {28'h0, tap_state}, 32'hA);
    check("shir_drv", {31'h0, jtag_TDO_driven}, 32'h1);
    @(posedge clock);
    #1;
    reset = 1'b0; jtag_TCK = 1'b0; jtag_TMS = 1'b1;
    @(posedge clock);
    #1;
    check("mid_rst_state", {28'h0, tap_state}, 32'hF);
    check("mid_rst_ir", {27'h0, ir_value}, 32'h1);
    check("mid_rst_drv", {31'h0, jtag_TDO_driven}, 32'h0);
    check("mid_rst_tdo", {31'h0, jtag_TDO_data}, 32'h0);
    check("mid_rst_valid", {31'h0, dr_update_valid}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    rises = 0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_state", {28'h0, tap_state}, 32'hF);
    check("post_rst_ir", {27'h0, ir_value}, 32'h1);
    check("total_pulses", pulse_cnt, 32'h1);
`ifdef JTAG_TAP_TCK_COUNT_EN
    check("tck_rise_count", tck_rise_count, rises);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
